// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs LSU) onto the regfile write port, plus a busy scoreboard.
// Define REGFILE_WB_BYPASS_EN to add forwarding ports and clear busy bits at the accept edge.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            sclk_i,
    input  logic            srst_i,
    input  logic            alu_valid_i,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    input  logic            lsu_valid_i,
    input  logic [AW-1:0]   lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    output logic            lsu_ready_o,
    input  logic            iss_valid_i,
    input  logic [AW-1:0]   iss_rd_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            rf_we_o,
    output logic [AW-1:0]   rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            err_o
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic            rs1_fwd_o,
    output logic            rs2_fwd_o,
    output logic [XLEN-1:0] rs1_fwd_data_o,
    output logic [XLEN-1:0] rs2_fwd_data_o
`endif
);

    logic            last_lsu_reg;
    logic            alu_grant;
    logic            lsu_grant;
    logic            any_grant;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            win_write;

    logic            rf_we_reg;
    logic [AW-1:0]   rf_waddr_reg;
    logic [XLEN-1:0] rf_wdata_reg;
    logic            err_reg;
    logic            err_next;

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            set_en;
    logic            clr_en;
    logic [AW-1:0]   clr_addr;

    // last_lsu_reg=1 means LSU won the previous grant, so ALU wins the next contention
    always_comb begin
        alu_grant = alu_valid_i & (~lsu_valid_i | last_lsu_reg);
        lsu_grant = lsu_valid_i & (~alu_valid_i | ~last_lsu_reg);
        any_grant = alu_grant | lsu_grant;
        win_rd    = alu_grant ? alu_rd_i   : lsu_rd_i;
        win_data  = alu_grant ? alu_data_i : lsu_data_i;
        win_write = any_grant & (win_rd != '0);
    end

    assign alu_ready_o = alu_grant;
    assign lsu_ready_o = lsu_grant;

    always_ff @(posedge sclk_i or negedge srst_i) begin
        if (!srst_i) begin
            last_lsu_reg <= 1'b1;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else begin
            if (any_grant) begin
                last_lsu_reg <= lsu_grant;
            end
            rf_we_reg <= win_write;
            if (win_write) begin
                rf_waddr_reg <= win_rd;
                rf_wdata_reg <= win_data;
            end
        end
    end

    assign rf_we_o    = rf_we_reg;
    assign rf_waddr_o = rf_waddr_reg;
    assign rf_wdata_o = rf_wdata_reg;

`ifdef REGFILE_WB_BYPASS_EN
    // Forwarding covers the write cycle, so the busy bit may drop as soon as the write is accepted
    assign clr_en   = win_write;
    assign clr_addr = win_rd;
`else
    // Hold busy until the edge after the write, when the regfile itself holds the data
    assign clr_en   = rf_we_reg;
    assign clr_addr = rf_waddr_reg;
`endif

    assign set_en = iss_valid_i & (iss_rd_i != '0);

    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (set_en && iss_rd_i == AW'(gi)) begin
                    busy_next[gi] = 1'b1;
                end else if (clr_en && clr_addr == AW'(gi)) begin
                    busy_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign err_next = err_reg
                    | (set_en & busy_reg[iss_rd_i] & ~(clr_en & (clr_addr == iss_rd_i)));

    always_ff @(posedge sclk_i or negedge srst_i) begin
        if (!srst_i) begin
            busy_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            err_reg  <= err_next;
        end
    end

    assign err_o      = err_reg;
    assign rs1_busy_o = busy_reg[rs1_addr_i];
    assign rs2_busy_o = busy_reg[rs2_addr_i];

`ifdef REGFILE_WB_BYPASS_EN
    assign rs1_fwd_o      = rf_we_reg & (rf_waddr_reg == rs1_addr_i) & (rs1_addr_i != '0);
    assign rs2_fwd_o      = rf_we_reg & (rf_waddr_reg == rs2_addr_i) & (rs2_addr_i != '0);
    assign rs1_fwd_data_o = rf_wdata_reg;
    assign rs2_fwd_data_o = rf_wdata_reg;
`endif

endmodule
